// File: rtl/mem_logger_pkg.sv
// Shared types and constants for the sample capture logger.
package mem_logger_pkg;

  // Capture FSM states.
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StPre  = 3'd1,
    StPost = 3'd2,
    StFull = 3'd3,
    StRead = 3'd4
  } state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_PRETRIG = 1'b1;

  // Post-trigger word count limited to 1..depth.
  function automatic int unsigned clamp_post(int unsigned req, int unsigned depth);
    if (req == 0) return 1;
    if (req > depth) return depth;
    return req;
  endfunction

endpackage

// File: rtl/mem_logger_if.sv
// Sample input, capture control, readback and status bundle of the logger.
interface mem_logger_if #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned NUM_LANES    = 2,
  parameter int unsigned ADDR_WIDTH   = 15,
  parameter int unsigned DECIM_WIDTH  = 8
);
  logic [SAMPLE_WIDTH-1:0]           i_filter_data;
  logic                              i_valid;
  logic                              i_run_log;
  logic                              i_mode;
  logic [DECIM_WIDTH-1:0]            i_decim;
  logic                              i_trigger;
  logic [ADDR_WIDTH:0]               i_post_words;
  logic                              i_stop_log;
  logic                              i_read_log;
  logic                              i_rd_en;
  logic [ADDR_WIDTH-1:0]             i_rd_addr;
  logic [NUM_LANES*SAMPLE_WIDTH-1:0] o_data_log_from_mem;
  logic                              o_rd_valid;
  logic                              o_mem_full;
  logic                              o_busy;
  logic [ADDR_WIDTH-1:0]             o_trig_addr;
  logic [ADDR_WIDTH-1:0]             o_start_addr;
  logic [ADDR_WIDTH:0]               o_words_written;

  modport master (
    output i_filter_data, i_valid, i_run_log, i_mode, i_decim, i_trigger, i_post_words,
    output i_stop_log, i_read_log, i_rd_en, i_rd_addr,
    input  o_data_log_from_mem, o_rd_valid, o_mem_full, o_busy, o_trig_addr, o_start_addr,
    input  o_words_written
  );

  modport slave (
    input  i_filter_data, i_valid, i_run_log, i_mode, i_decim, i_trigger, i_post_words,
    input  i_stop_log, i_read_log, i_rd_en, i_rd_addr,
    output o_data_log_from_mem, o_rd_valid, o_mem_full, o_busy, o_trig_addr, o_start_addr,
    output o_words_written
  );
endinterface

// File: rtl/mem_logger_log_bram.sv
// Single-port sample bank: synchronous write, registered read.
module mem_logger_log_bram #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH   = 15
) (
  input  logic                    clk,
  input  logic                    i_rst,
  input  logic                    i_we,
  input  logic                    i_re,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [SAMPLE_WIDTH-1:0] i_wdata,
  output logic [SAMPLE_WIDTH-1:0] o_rdata
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [SAMPLE_WIDTH-1:0] r_mem [DEPTH];
  logic [SAMPLE_WIDTH-1:0] r_rdata;

  // Storage array, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  // Read data register, held between reads.
  always_ff @(posedge clk) begin
    if (i_rst)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/mem_logger.sv
// Capture logger: decimator, lane/word pointers and capture FSM over NUM_LANES banks.
module mem_logger
  import mem_logger_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned NUM_LANES    = 2,
  parameter int unsigned ADDR_WIDTH   = 15,
  parameter int unsigned DECIM_WIDTH  = 8
) (
  input  logic         clk,
  input  logic         i_rst,
  mem_logger_if.slave  bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned LaneW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [LaneW-1:0]    LastLane = LaneW'(NUM_LANES - 1);

  state_e                  r_state;
  logic [DECIM_WIDTH-1:0]  r_decim, r_dcnt;
  logic [LaneW-1:0]        r_lane;
  logic [ADDR_WIDTH-1:0]   r_wptr, r_trig_addr, r_start_addr;
  logic                    r_wrapped, r_busy, r_full, r_rd_valid;
  logic [ADDR_WIDTH:0]     r_words, r_remaining;

  logic                    w_capturing, w_accept, w_word_done, w_to_full, w_rd_en;
  logic [LaneW-1:0]        w_lane_nxt;
  logic [ADDR_WIDTH-1:0]   w_wptr_nxt, w_start_full, w_addr;
  logic                    w_wrap_nxt;
  logic [ADDR_WIDTH:0]     w_words_nxt, w_words_stop, w_post_clamp, w_rem_trig, w_rem_post;
  logic [DECIM_WIDTH-1:0]  w_dcnt_nxt;
  logic [NUM_LANES-1:0]    w_we;
  logic [NUM_LANES-1:0][SAMPLE_WIDTH-1:0] w_rdata;

  // Next-state values of the write datapath for the current cycle.
  always_comb begin
    w_capturing  = (r_state == StPre) || (r_state == StPost);
    w_accept     = w_capturing && bus.i_valid && (r_dcnt == '0);
    w_word_done  = w_accept && (r_lane == LastLane);
    w_lane_nxt   = r_lane;
    if (w_accept) w_lane_nxt = w_word_done ? '0 : r_lane + LaneW'(1);
    w_wptr_nxt   = w_word_done ? r_wptr + ADDR_WIDTH'(1) : r_wptr;
    w_wrap_nxt   = r_wrapped | (w_word_done && (r_wptr == '1));
    w_words_nxt  = (w_word_done && (r_words != DepthCnt)) ? r_words + 1'b1 : r_words;
    // A partially filled word still counts as captured.
    w_words_stop = ((w_lane_nxt != '0) && (w_words_nxt != DepthCnt)) ?
                   w_words_nxt + 1'b1 : w_words_nxt;
    w_start_full = w_wrap_nxt ? w_wptr_nxt : '0;
    w_dcnt_nxt   = r_dcnt;
    if (w_capturing && bus.i_valid) w_dcnt_nxt = (r_dcnt == '0) ? r_decim : r_dcnt - 1'b1;
    w_post_clamp = (ADDR_WIDTH+1)'(clamp_post(32'(bus.i_post_words), DEPTH));
    // The trigger-cycle sample already belongs to the post-trigger window.
    w_rem_trig   = w_post_clamp - {{ADDR_WIDTH{1'b0}}, w_word_done};
    w_rem_post   = r_remaining - {{ADDR_WIDTH{1'b0}}, w_word_done};
    w_to_full    = (w_capturing && bus.i_stop_log) ||
                   ((r_state == StPost) && (w_rem_post == '0)) ||
                   ((r_state == StPre) && bus.i_trigger && (w_rem_trig == '0));
    w_rd_en      = (r_state == StRead) && bus.i_rd_en && !bus.i_run_log;
    w_addr       = (r_state == StRead) ? bus.i_rd_addr : r_wptr;
  end

  // Capture FSM with pointers, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_decim      <= '0;
      r_dcnt       <= '0;
      r_lane       <= '0;
      r_wptr       <= '0;
      r_wrapped    <= 1'b0;
      r_words      <= '0;
      r_remaining  <= '0;
      r_trig_addr  <= '0;
      r_start_addr <= '0;
      r_busy       <= 1'b0;
      r_full       <= 1'b0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_en;
      unique case (r_state)
        StIdle, StFull, StRead: begin
          if (bus.i_run_log) begin
            r_state      <= (bus.i_mode == MODE_PRETRIG) ? StPre : StPost;
            r_decim      <= bus.i_decim;
            r_dcnt       <= '0;
            r_lane       <= '0;
            r_wptr       <= '0;
            r_wrapped    <= 1'b0;
            r_words      <= '0;
            r_remaining  <= DepthCnt;
            r_trig_addr  <= '0;
            r_start_addr <= '0;
            r_busy       <= 1'b1;
            r_full       <= 1'b0;
          end else if ((r_state == StFull) && bus.i_read_log) begin
            r_state <= StRead;
          end
        end
        StPre, StPost: begin
          r_lane    <= w_lane_nxt;
          r_wptr    <= w_wptr_nxt;
          r_wrapped <= w_wrap_nxt;
          r_words   <= w_words_nxt;
          r_dcnt    <= w_dcnt_nxt;
          if ((r_state == StPre) && bus.i_trigger && !bus.i_stop_log) r_trig_addr <= r_wptr;
          if (w_to_full) begin
            r_state      <= StFull;
            r_words      <= w_words_stop;
            r_start_addr <= w_start_full;
            r_busy       <= 1'b0;
            r_full       <= 1'b1;
          end else if (r_state == StPost) begin
            r_remaining <= w_rem_post;
          end else if (bus.i_trigger) begin
            r_state     <= StPost;
            r_remaining <= w_rem_trig;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign w_we[l] = w_accept && (r_lane == LaneW'(l));
    mem_logger_log_bram #(
      .SAMPLE_WIDTH(SAMPLE_WIDTH),
      .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_bram (
      .clk    (clk),
      .i_rst  (i_rst),
      .i_we   (w_we[l]),
      .i_re   (w_rd_en),
      .i_addr (w_addr),
      .i_wdata(bus.i_filter_data),
      .o_rdata(w_rdata[l])
    );
  end

  assign bus.o_data_log_from_mem = w_rdata;
  assign bus.o_rd_valid          = r_rd_valid;
  assign bus.o_mem_full          = r_full;
  assign bus.o_busy              = r_busy;
  assign bus.o_trig_addr         = r_trig_addr;
  assign bus.o_start_addr        = r_start_addr;
  assign bus.o_words_written     = r_words;
endmodule

// File: tb/tb_mem_logger.sv
// Bench for mem_logger: directed scenarios plus randomized captures against a sample-index model.
module tb_mem_logger;
  localparam int SW = 16, NL = 2, AW = 4, DW = 8, DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_logger_if #(.SAMPLE_WIDTH(SW), .NUM_LANES(NL), .ADDR_WIDTH(AW), .DECIM_WIDTH(DW)) bus ();

  mem_logger #(.SAMPLE_WIDTH(SW), .NUM_LANES(NL), .ADDR_WIDTH(AW), .DECIM_WIDTH(DW)) dut (
    .clk  (clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: what the banks should hold and where the capture should end.
  logic [15:0] m_mem   [DEPTH][NL];
  bit          m_known [DEPTH][NL];
  logic [31:0] rd_obs  [DEPTH];
  bit          m_mode, m_done, m_trigd;
  int          m_decim, m_k, m_vcnt, m_limit, m_trig_word;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.i_filter_data = '0; bus.i_valid = 0; bus.i_run_log = 0; bus.i_mode = 0;
    bus.i_decim = '0; bus.i_trigger = 0; bus.i_post_words = '0; bus.i_stop_log = 0;
    bus.i_read_log = 0; bus.i_rd_en = 0; bus.i_rd_addr = '0;
  endtask

  task automatic forget_mem();
    for (int w = 0; w < DEPTH; w++) for (int l = 0; l < NL; l++) m_known[w][l] = 0;
  endtask

  task automatic start_cap(bit mode, int decim);
    bus.i_mode = mode; bus.i_decim = 8'(decim); bus.i_run_log = 1; bus.i_valid = 0;
    step();
    bus.i_run_log = 0;
    m_mode = mode; m_decim = decim; m_k = 0; m_vcnt = 0; m_done = 0; m_trigd = 0;
    m_limit = mode ? 32'h3fff_ffff : DEPTH * NL;
    check("start_full_low", {31'd0, bus.o_mem_full}, 32'd0);
    check("start_busy_high", {31'd0, bus.o_busy}, 32'd1);
    check("start_words_clear", 32'(bus.o_words_written), 32'd0);
  endtask

  // One sample cycle: drive, clock, advance the model, compare status timing.
  task automatic cycle(logic [15:0] data, bit valid, bit trig, bit stop, int post);
    int p, e;
    bus.i_filter_data = data; bus.i_valid = valid; bus.i_trigger = trig;
    bus.i_stop_log = stop; bus.i_post_words = 5'(post);
    step();
    if (!m_done) begin
      if (stop) begin
        m_done = 1;
      end else begin
        if (trig && m_mode && !m_trigd) begin
          m_trigd     = 1;
          m_trig_word = (m_k / NL) % DEPTH;
          p = (post == 0) ? 1 : ((post > DEPTH) ? DEPTH : post);
          e = (m_k % NL == NL - 1) ? m_k : m_k + (NL - 1 - m_k % NL);
          m_limit = e + NL * (p - 1) + 1;
        end
        if (valid) begin
          if (m_vcnt % (m_decim + 1) == 0) begin
            m_mem[(m_k / NL) % DEPTH][m_k % NL]   = data;
            m_known[(m_k / NL) % DEPTH][m_k % NL] = 1;
            m_k++;
          end
          m_vcnt++;
        end
        if (m_k == m_limit) m_done = 1;
      end
    end
    check("full_timing", {31'd0, bus.o_mem_full}, {31'd0, m_done});
    check("busy_timing", {31'd0, bus.o_busy}, {31'd0, !m_done});
  endtask

  task automatic run_cap(int n, int trig_at, int post, int stop_at, int vprob, bit rnd, int base);
    for (int i = 0; i < n; i++) begin
      cycle(rnd ? 16'($urandom) : 16'(base + i),
            (i != stop_at) && ($urandom_range(99) < vprob), i == trig_at, i == stop_at, post);
    end
    // Closing stop: ends an open capture, ignored once FULL.
    cycle(16'hdead, 1'b0, 1'b0, 1'b1, post);
    bus.i_stop_log = 0; bus.i_trigger = 0; bus.i_valid = 0;
  endtask

  task automatic check_status(string tag);
    int words_exp, start_exp;
    words_exp = (m_k + NL - 1) / NL;
    if (words_exp > DEPTH) words_exp = DEPTH;
    start_exp = (m_k / NL >= DEPTH) ? (m_k / NL) % DEPTH : 0;
    check({tag, "_words"}, 32'(bus.o_words_written), 32'(words_exp));
    check({tag, "_start"}, 32'(bus.o_start_addr), 32'(start_exp));
    if (m_trigd) check({tag, "_trig"}, 32'(bus.o_trig_addr), 32'(m_trig_word));
  endtask

  task automatic read_all(string tag);
    bus.i_read_log = 1; bus.i_rd_en = 1; bus.i_rd_addr = '0;
    step();
    bus.i_read_log = 0;
    check({tag, "_rd_ignored_in_full"}, {31'd0, bus.o_rd_valid}, 32'd0);
    check({tag, "_full_in_read"}, {31'd0, bus.o_mem_full}, 32'd1);
    for (int w = 0; w < DEPTH; w++) begin
      bus.i_rd_en = 1; bus.i_rd_addr = 4'(w);
      step();
      rd_obs[w] = bus.o_data_log_from_mem;
      check({tag, "_rd_valid"}, {31'd0, bus.o_rd_valid}, 32'd1);
      for (int l = 0; l < NL; l++)
        if (m_known[w][l]) check({tag, "_rd_data"}, 32'(rd_obs[w][l*SW +: SW]), 32'(m_mem[w][l]));
    end
    bus.i_rd_en = 0;
    step();
    check({tag, "_rd_valid_drop"}, {31'd0, bus.o_rd_valid}, 32'd0);
  endtask

  initial begin
    idle_in();
    forget_mem();
    // Reset state; trigger and read_log must be ignored in IDLE.
    rst = 1; step(); step(); rst = 0;
    check("rst_full", {31'd0, bus.o_mem_full}, 32'd0);
    check("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    check("rst_rd_valid", {31'd0, bus.o_rd_valid}, 32'd0);
    check("rst_trig", 32'(bus.o_trig_addr), 32'd0);
    check("rst_start", 32'(bus.o_start_addr), 32'd0);
    check("rst_words", 32'(bus.o_words_written), 32'd0);
    check("rst_data", bus.o_data_log_from_mem, 32'd0);
    bus.i_trigger = 1; bus.i_read_log = 1; bus.i_rd_en = 1; step();
    idle_in();
    check("idle_ignore_full", {31'd0, bus.o_mem_full}, 32'd0);
    check("idle_ignore_busy", {31'd0, bus.o_busy}, 32'd0);
    check("idle_ignore_rd", {31'd0, bus.o_rd_valid}, 32'd0);

    // One-shot, no decimation, samples 0..31.
    start_cap(1'b0, 0);
    run_cap(32, -1, 0, -1, 100, 1'b0, 0);
    check_status("oneshot");
    check("oneshot_words16", 32'(bus.o_words_written), 32'd16);
    read_all("oneshot");
    check("oneshot_w5", rd_obs[5], {16'd11, 16'd10});

    // Decimation by 3.
    start_cap(1'b0, 2);
    run_cap(96, -1, 0, -1, 100, 1'b0, 0);
    check_status("decim");
    read_all("decim");
    check("decim_w0", rd_obs[0], {16'd3, 16'd0});
    check("decim_w1", rd_obs[1], {16'd9, 16'd6});

    // Pre-trigger with trigger on sample 32, four post words.
    start_cap(1'b1, 0);
    run_cap(40, 32, 4, -1, 100, 1'b0, 0);
    check_status("pretrig");
    check("pretrig_trig0", 32'(bus.o_trig_addr), 32'd0);
    check("pretrig_start4", 32'(bus.o_start_addr), 32'd4);
    read_all("pretrig");
    check("pretrig_w4", rd_obs[4], {16'd9, 16'd8});
    check("pretrig_w3", rd_obs[3], {16'd39, 16'd38});

    // Early stop after five accepted samples.
    start_cap(1'b0, 0);
    run_cap(6, -1, 0, 5, 100, 1'b0, 0);
    check_status("stop");
    check("stop_words3", 32'(bus.o_words_written), 32'd3);
    read_all("stop");
    check("stop_w2_lane0", 32'(rd_obs[2][15:0]), 32'd4);

    // Reset in the middle of a capture, then a fresh one-shot capture.
    start_cap(1'b0, 0);
    for (int i = 0; i < 10; i++) cycle(16'(50 + i), 1'b1, 1'b0, 1'b0, 0);
    rst = 1; step(); rst = 0;
    forget_mem();
    check("midrst_full", {31'd0, bus.o_mem_full}, 32'd0);
    check("midrst_busy", {31'd0, bus.o_busy}, 32'd0);
    check("midrst_words", 32'(bus.o_words_written), 32'd0);
    start_cap(1'b0, 0);
    run_cap(32, -1, 0, -1, 100, 1'b0, 100);
    check_status("restart");
    read_all("restart");
    check("restart_w0", rd_obs[0], {16'd101, 16'd100});

    // Randomized captures: mode, decimation, gaps, trigger point, post length, early stop.
    for (int it = 0; it < 8; it++) begin
      bit md;
      int dc, trig_at, stop_at, post, vprob;
      md      = 1'($urandom_range(1));
      dc      = $urandom_range(3);
      vprob   = $urandom_range(100, 50);
      post    = $urandom_range(31);
      trig_at = md ? $urandom_range(80, 5) : -1;
      stop_at = ($urandom_range(2) == 0) ? $urandom_range(150, 3) : -1;
      start_cap(md, dc);
      run_cap(300, trig_at, post, stop_at, vprob, 1'b1, 0);
      check_status("rand");
      read_all("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_logger.md
# mem_logger

Parametrised successor to the two-bank I/Q capture logger. Stores decimated filter samples in NUM_LANES parallel single-port banks, one sample per lane, packed lane by lane into words. Supports one-shot fill and circular pre-trigger capture, early stop, and registered word readback. Sits between the filter chain output and the host readout/register interface.

## Interface
- SAMPLE_WIDTH, 16: bits per stored sample.
- NUM_LANES, 2: banks per word; read word is NUM_LANES*SAMPLE_WIDTH bits, lane 0 in the LSBs.
- ADDR_WIDTH, 15: word address bits; DEPTH = 2**ADDR_WIDTH words.
- DECIM_WIDTH, 8: width of the decimation control.
- clk  in  1  clock, single domain.
- i_rst  in  1  synchronous, active-high reset.
- i_filter_data  in  SAMPLE_WIDTH  sample.
- i_valid  in  1  sample qualifier.
- i_run_log  in  1  start/restart capture (level, sampled per cycle).
- i_mode  in  1  0 = one-shot, 1 = circular pre-trigger; sampled on start.
- i_decim  in  DECIM_WIDTH  store 1 of every i_decim+1 valid samples; sampled on start.
- i_trigger  in  1  trigger, mode 1 only.
- i_post_words  in  ADDR_WIDTH+1  words written after trigger; sampled at trigger, clamped to 1..DEPTH.
- i_stop_log  in  1  end capture early.
- i_read_log  in  1  enter read mode from FULL.
- i_rd_en  in  1  read request in READ.
- i_rd_addr  in  ADDR_WIDTH  read word address.
- o_data_log_from_mem  out  NUM_LANES*SAMPLE_WIDTH  read word.
- o_rd_valid  out  1  data valid.
- o_mem_full  out  1  capture finished (FULL or READ).
- o_busy  out  1  in PRE or POST.
- o_trig_addr  out  ADDR_WIDTH  word pointer at trigger.
- o_start_addr  out  ADDR_WIDTH  oldest word of the capture.
- o_words_written  out  ADDR_WIDTH+1  valid words in the capture.

## Operation
- States: IDLE, PRE, POST, FULL, READ. Reset → IDLE; all outputs, pointers and counters 0.
- IDLE: i_run_log → PRE (mode 1) or POST with remaining = DEPTH (mode 0). Pointers, decimation counter and word count cleared.
- Accept = i_valid && decimation counter == 0. Counter reloads to i_decim on every valid sample where it is 0, otherwise decrements on valid.
- An accepted sample is written to bank[lane] at word pointer. Lane increments; after lane NUM_LANES-1 the lane returns to 0, the word pointer increments mod DEPTH, and the word count saturates at DEPTH.
- PRE: writing wraps freely. i_trigger → POST. Latch o_trig_addr = word pointer and remaining = clamp(i_post_words). The trigger-cycle sample belongs to POST.
- POST: remaining decrements on each completed word; reaching 0 → FULL. Trigger is ignored.
- i_stop_log in PRE or POST → FULL. A partial word counts in o_words_written; unwritten lanes keep stale data.
- On entry to FULL: o_start_addr = 0 if no wrap occurred, else the word pointer (oldest word).
- FULL: i_run_log restarts (→ IDLE actions, then PRE/POST next cycle). Else i_read_log → READ.
- READ: i_rd_en reads i_rd_addr from all banks. i_run_log restarts and has priority over i_rd_en.
- Priority when simultaneous: i_rst > i_stop_log > completion > i_trigger.
- i_trigger, i_read_log and i_rd_en are ignored outside their states.
- No writes occur in IDLE, FULL or READ.

## Timing
- Write occurs at the edge ending the accept cycle.
- o_mem_full rises the cycle after the final write or stop cycle.
- o_busy is high starting the cycle after the start cycle.
- Read latency is 1 cycle. Data and o_rd_valid are registered and appear the cycle after i_rd_en. Back-to-back reads run at one word per cycle.
- Reset mid-capture: IDLE next cycle, o_mem_full = 0. Memory contents are undefined for readout until a new capture completes.
- Restart from FULL/READ: o_mem_full falls the cycle after i_run_log.

## Structure
- Shared package: state encoding localparams (IDLE, PRE, POST, FULL, READ), mode constants (MODE_ONESHOT = 0, MODE_PRETRIG = 1).
- One sub-module, log_bram: single-port synchronous RAM with registered output, SAMPLE_WIDTH × DEPTH, per-bank write enable. Instantiated NUM_LANES times in a generate loop.
- The top level holds the FSM, decimator, lane/word pointers and counters.

## Test plan
All scenarios use ADDR_WIDTH = 4, NUM_LANES = 2, SAMPLE_WIDTH = 16. Samples are value = index; i_valid is continuous unless stated.
- Reset: after i_rst, all outputs are 0 and state is IDLE; i_trigger and i_read_log are ignored.
- One-shot, i_decim = 0, samples 0..31:
  - o_mem_full rises the cycle after sample 31.
  - o_words_written = 16, o_start_addr = 0.
  - Read addr 5 → {11,10}, one cycle later with o_rd_valid.
- Decimation, i_decim = 2: stored sequence is 0,3,6,…; word 0 = {3,0}, word 1 = {9,6}.
- Pre-trigger, mode 1, samples 0..39, i_trigger with sample 32, i_post_words = 4:
  - FULL after sample 39.
  - o_trig_addr = 0, o_start_addr = 4, o_words_written = 16.
  - Word 4 = {9,8}, word 3 = {39,38}.
- Early stop, one-shot: i_stop_log after 5 accepted samples → FULL, o_words_written = 3, word 2 lane 0 = 4.
- Reset during POST, then restart with mode 0: the new capture completes normally and the word 0 read returns the new samples.
